// File: rtl/gf180mcu_ocd_io__dvdd_seq.sv
// rtl/gf180mcu_ocd_io__dvdd_seq.sv - DVDD IO ring power sequencer
// Debounces the DVDD good comparator and orders isolation release and pad-driver enable.
module gf180mcu_ocd_io__dvdd_seq #(
  parameter int DEB_CYCLES = 16,
  parameter int ISO_DELAY  = 4,
  parameter int CW         = 8
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       PG_IN,
  input  logic       SEQ_EN,
  output logic       PAD_EN,
  output logic       ISO_N,
  output logic       PGOOD,
  output logic       FAULT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_ISO_REL  = 3'd2,
    S_ON       = 3'd3,
    S_SHUTDOWN = 3'd4,
    S_FAULT    = 3'd5
  } state_e;

  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] ISO_LAST = CW'(ISO_DELAY - 1);

  logic          pg_meta_q;
  logic          pg_s_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pg_meta_q <= 1'b0;
      pg_s_q    <= 1'b0;
      state_q   <= S_OFF;
      cnt_q     <= '0;
    end else begin
      pg_meta_q <= PG_IN;
      pg_s_q    <= pg_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_OFF: begin
        if (pg_s_q && SEQ_EN) begin
          state_d = S_DEBOUNCE;
          cnt_d   = '0;
        end
      end
      S_DEBOUNCE: begin
        // Losing the supply before it was declared good is not a fault.
        if (!pg_s_q || !SEQ_EN) begin
          state_d = S_OFF;
        end else if (cnt_q == DEB_LAST) begin
          state_d = S_ISO_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ISO_REL: begin
        if (!pg_s_q) begin
          state_d = S_FAULT;
        end else if (!SEQ_EN) begin
          state_d = S_SHUTDOWN;
          cnt_d   = '0;
        end else if (cnt_q == ISO_LAST) begin
          state_d = S_ON;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ON: begin
        if (!pg_s_q) begin
          state_d = S_FAULT;
        end else if (!SEQ_EN) begin
          state_d = S_SHUTDOWN;
          cnt_d   = '0;
        end
      end
      S_SHUTDOWN: begin
        // Once started, shutdown runs to completion regardless of SEQ_EN.
        if (!pg_s_q || (cnt_q == ISO_LAST)) begin
          state_d = S_OFF;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FAULT: begin
        if (!SEQ_EN) begin
          state_d = S_OFF;
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase
  end

  always_comb begin
    PGOOD  = (state_q == S_ISO_REL) || (state_q == S_ON) || (state_q == S_SHUTDOWN);
    ISO_N  = PGOOD;
    PAD_EN = (state_q == S_ON);
    FAULT  = (state_q == S_FAULT);
    STATE  = state_q;
  end

endmodule

// File: tb/tb_gf180mcu_ocd_io__dvdd_seq.sv
// tb/tb_gf180mcu_ocd_io__dvdd_seq.sv - directed self-checking bench for the DVDD sequencer
module tb_gf180mcu_ocd_io__dvdd_seq;

  logic       CLK;
  logic       RSTN;
  logic       PG_IN;
  logic       SEQ_EN;
  logic       PAD_EN;
  logic       ISO_N;
  logic       PGOOD;
  logic       FAULT;
  logic [2:0] STATE;

  int n_checks = 0;
  int n_errors = 0;

  gf180mcu_ocd_io__dvdd_seq #(
    .DEB_CYCLES(16),
    .ISO_DELAY (4),
    .CW        (8)
  ) dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .PG_IN (PG_IN),
    .SEQ_EN(SEQ_EN),
    .PAD_EN(PAD_EN),
    .ISO_N (ISO_N),
    .PGOOD (PGOOD),
    .FAULT (FAULT),
    .STATE (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic outs(input string tag, input logic pad, input logic iso,
                      input logic pg, input logic flt, input logic [2:0] st);
    chk({tag, ".pad_en"}, 32'(PAD_EN), 32'(pad));
    chk({tag, ".iso_n"},  32'(ISO_N),  32'(iso));
    chk({tag, ".pgood"},  32'(PGOOD),  32'(pg));
    chk({tag, ".fault"},  32'(FAULT),  32'(flt));
    chk({tag, ".state"},  32'(STATE),  32'(st));
  endtask

  task automatic power_up(input string tag);
    int n = 0;
    SEQ_EN = 1'b1;
    PG_IN  = 1'b1;
    while (STATE != 3'd3 && n < 80) begin
      tick(1);
      n++;
    end
    chk({tag, ".reached_on"}, 32'(STATE), 32'd3);
  endtask

  initial begin
    logic pgood_seen;
    RSTN   = 1'b0;
    PG_IN  = 1'b0;
    SEQ_EN = 1'b0;
    tick(3);
    outs("reset", 0, 0, 0, 0, 3'd0);
    RSTN = 1'b1;

    // Power-up with defaults: PG_IN and SEQ_EN high before edge 1.
    SEQ_EN = 1'b1;
    PG_IN  = 1'b1;
    tick(2);
    chk("pu.e2.state", 32'(STATE), 32'd0);
    tick(1);
    chk("pu.e3.state", 32'(STATE), 32'd1);
    tick(15);
    outs("pu.e18", 0, 0, 0, 0, 3'd1);
    tick(1);
    outs("pu.e19", 0, 1, 1, 0, 3'd2);
    tick(3);
    chk("pu.e22.pad_en", 32'(PAD_EN), 32'd0);
    tick(1);
    outs("pu.e23", 1, 1, 1, 0, 3'd3);

    // Brown-out from ON, then supply recovers while the fault is held.
    PG_IN = 1'b0;
    tick(2);
    outs("bo.e2", 1, 1, 1, 0, 3'd3);
    tick(1);
    outs("bo.e3", 0, 0, 0, 1, 3'd5);
    PG_IN = 1'b1;
    tick(5);
    outs("bo.recover", 0, 0, 0, 1, 3'd5);
    SEQ_EN = 1'b0;
    tick(1);
    outs("bo.clear", 0, 0, 0, 0, 3'd0);

    // Orderly shutdown; SEQ_EN re-asserted mid-way must not abort it.
    power_up("sd");
    SEQ_EN = 1'b0;
    tick(1);
    outs("sd.e1", 0, 1, 1, 0, 3'd4);
    SEQ_EN = 1'b1;
    tick(3);
    outs("sd.e4", 0, 1, 1, 0, 3'd4);
    tick(1);
    outs("sd.e5", 0, 0, 0, 0, 3'd0);
    SEQ_EN = 1'b0;
    tick(1);
    chk("sd.stay_off", 32'(STATE), 32'd0);

    // Supply loss and SEQ_EN drop seen on the same edge: fault wins.
    power_up("sim");
    PG_IN = 1'b0;
    tick(2);
    SEQ_EN = 1'b0;
    tick(1);
    outs("sim", 0, 0, 0, 1, 3'd5);
    tick(1);
    chk("sim.exit", 32'(STATE), 32'd0);

    // Glitch reject: 10 cycles of supply-good are not enough.
    PG_IN      = 1'b1;
    SEQ_EN     = 1'b1;
    pgood_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      pgood_seen |= PGOOD;
    end
    chk("gl.debounce", 32'(STATE), 32'd1);
    PG_IN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      pgood_seen |= PGOOD;
    end
    chk("gl.pgood_seen", 32'(pgood_seen), 32'd0);
    outs("gl.end", 0, 0, 0, 0, 3'd0);

    // Reset mid-ISO_REL at cnt=2, then a full sequence again.
    PG_IN = 1'b1;
    tick(21);
    outs("ri.iso_rel", 0, 1, 1, 0, 3'd2);
    #2 RSTN = 1'b0;
    #1;
    outs("ri.async", 0, 0, 0, 0, 3'd0);
    tick(2);
    RSTN = 1'b1;
    tick(18);
    chk("ri.e18.pgood", 32'(PGOOD), 32'd0);
    tick(1);
    outs("ri.e19", 0, 1, 1, 0, 3'd2);

    // Reset while in FAULT_ST.
    power_up("rf");
    PG_IN = 1'b0;
    tick(3);
    chk("rf.fault", 32'(FAULT), 32'd1);
    #2 RSTN = 1'b0;
    #1;
    outs("rf.async", 0, 0, 0, 0, 3'd0);
    tick(1);
    RSTN = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
